// File: rtl/clock_divider_prog.sv
// NCH independent programmable clock-enable dividers (divisor D, high-time H).
// New settings wait in a pending slot and switch over at a period boundary, disable or sync.
module clock_divider_prog #(
  parameter int NCH          = 4,
  parameter int DW           = 16,
  parameter int DEFAULT_DIV  = 16,
  parameter int DEFAULT_HIGH = 8,
  localparam int CW          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  input  logic           wr_en,
  input  logic [CW-1:0]  wr_ch,
  input  logic [DW-1:0]  wr_div,
  input  logic [DW-1:0]  wr_high,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pending,
  output logic           wr_err
);

  logic [DW-1:0]  cnt_q   [NCH];
  logic [DW-1:0]  cnt_d   [NCH];
  logic [DW-1:0]  div_q   [NCH];
  logic [DW-1:0]  div_d   [NCH];
  logic [DW-1:0]  high_q  [NCH];
  logic [DW-1:0]  high_d  [NCH];
  logic [DW-1:0]  pdiv_q  [NCH];
  logic [DW-1:0]  pdiv_d  [NCH];
  logic [DW-1:0]  phigh_q [NCH];
  logic [DW-1:0]  phigh_d [NCH];

  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] clk_out_q, clk_out_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] at_end, apply, wr_hit;
  logic           wr_ok;
  logic           wr_err_q, wr_err_d;

  assign wr_ok = wr_en
              && (32'(wr_ch) < 32'(NCH))
              && (wr_div >= DW'(2))
              && (wr_high != '0)
              && (wr_high < wr_div);

  // A pending setting is handed over whenever the counter is (re)started at zero.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign at_end[g] = (cnt_q[g] == div_q[g] - DW'(1));
    assign apply[g]  = pend_q[g] && (sync || !en[g] || at_end[g]);
    assign wr_hit[g] = wr_ok && (32'(wr_ch) == 32'(g));
  end

  always_comb begin
    clk_out_d = '0;
    tick_d    = '0;
    pend_d    = pend_q;
    wr_err_d  = wr_en && !wr_ok;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]   = cnt_q[i];
      div_d[i]   = div_q[i];
      high_d[i]  = high_q[i];
      pdiv_d[i]  = pdiv_q[i];
      phigh_d[i] = phigh_q[i];

      if (sync || !en[i]) begin
        cnt_d[i] = '0;
      end else begin
        clk_out_d[i] = (cnt_q[i] < high_q[i]);
        tick_d[i]    = (cnt_q[i] == '0);
        cnt_d[i]     = at_end[i] ? '0 : cnt_q[i] + DW'(1);
      end

      if (apply[i]) begin
        div_d[i]  = pdiv_q[i];
        high_d[i] = phigh_q[i];
        pend_d[i] = 1'b0;
      end

      // A write on the handover edge only refills the pending slot.
      if (wr_hit[i]) begin
        pdiv_d[i]  = wr_div;
        phigh_d[i] = wr_high;
        pend_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]   <= '0;
        div_q[i]   <= DW'(DEFAULT_DIV);
        high_q[i]  <= DW'(DEFAULT_HIGH);
        pdiv_q[i]  <= DW'(DEFAULT_DIV);
        phigh_q[i] <= DW'(DEFAULT_HIGH);
      end
      pend_q    <= '0;
      clk_out_q <= '0;
      tick_q    <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        div_q[i]   <= div_d[i];
        high_q[i]  <= high_d[i];
        pdiv_q[i]  <= pdiv_d[i];
        phigh_q[i] <= phigh_d[i];
      end
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pending = pend_q;
  assign wr_err  = wr_err_q;

endmodule
